mips_ex_stage: RTL and testbench

//   Registered execute stage directly downstream of the ALU control decoder.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_alu_core.sv | 48 ++++
 rtl/mips_ex_stage.sv | 106 ++++++++++
 tb/tb_mips_ex_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared ALU control encodings used by the ALU control decoder and the execute stage.
package mips_pkg;

    localparam int ALU_CTR_W = 4;

    typedef enum logic [ALU_CTR_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_ctr_e;

    function automatic logic alu_ctr_legal(input logic [ALU_CTR_W-1:0] ctr);
        logic legal;
        legal = 1'b0;
        case (ctr)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mips_alu_core.sv
// Combinational ALU: add/sub/and/or/slt with zero, signed overflow and illegal-code flags.
module mips_alu_core
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ALU_CTR_W-1:0] ctr,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     result,
    output logic                 zero,
    output logic                 overflow,
    output logic                 illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             a_lt_b;

    assign sum  = a + b;
    assign diff = a - b;

    // Direct signed compare stays correct where the sign of a-b would lie on overflow.
    assign a_lt_b = $signed(a) < $signed(b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (ctr)
            ALU_ADD: begin
                result   = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, a_lt_b};
            default: result = '0;
        endcase
    end

    assign zero    = (result == '0);
    assign illegal = !alu_ctr_legal(ctr);

endmodule

// File: rtl/mips_ex_stage.sv
// Registered execute stage: ALU core feeding a 2-entry skid buffer with valid/ready on both sides.
module mips_ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALU_CTR_W-1:0] alu_ctr,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 zero,
    output logic                 overflow,
    output logic                 illegal
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             overflow;
        logic             illegal;
    } entry_t;

    entry_t alu_entry;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q;
    logic   accept;
    logic   pop;

    mips_alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .ctr      (alu_ctr),
        .a        (op_a),
        .b        (op_b),
        .result   (alu_entry.result),
        .zero     (alu_entry.zero),
        .overflow (alu_entry.overflow),
        .illegal  (alu_entry.illegal)
    );

    assign accept = in_valid && in_ready_q;
    assign pop    = main_valid_q && out_ready;

    // Skid may only fill while main is stalled; in_ready drops the cycle it does.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = alu_entry;
                main_valid_d = 1'b1;
            end
        end else if (pop) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = alu_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = alu_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign result    = main_q.result;
    assign zero      = main_q.zero;
    assign overflow  = main_q.overflow;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_mips_ex_stage.sv
// Self-checking bench for mips_ex_stage: directed corner cases plus random traffic vs a queue model.
module tb_mips_ex_stage;
    import mips_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        overflow;
        logic        illegal;
    } ref_entry_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctr;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    int testsRun    = 0;
    int testsFailed = 0;

    ref_entry_t modelQ[$];

    mips_ex_stage #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctr   (alu_ctr),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference ALU computed with wide signed arithmetic instead of sign-bit rules.
    function automatic ref_entry_t refAlu(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
        ref_entry_t e;
        longint     sa;
        longint     sb;
        longint     full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.result   = 32'h0;
        e.overflow = 1'b0;
        e.illegal  = 1'b0;
        case (ctr)
            4'b0010: begin
                full       = sa + sb;
                e.result   = full[31:0];
                e.overflow = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'b0110: begin
                full       = sa - sb;
                e.result   = full[31:0];
                e.overflow = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b0111: e.result = (sa < sb) ? 32'd1 : 32'd0;
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == 32'h0);
        return e;
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare at the following negedge.
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic r, input logic f, input logic rn);
        logic modelReady;
        logic modelValid;
        in_valid  = v;
        alu_ctr   = c;
        op_a      = a;
        op_b      = b;
        out_ready = r;
        flush     = f;
        rst_n     = rn;
        @(posedge clk);
        modelReady = (modelQ.size() < 2);
        modelValid = (modelQ.size() > 0);
        if (!rn || f) begin
            modelQ.delete();
        end else begin
            if (modelValid && r) void'(modelQ.pop_front());
            if (v && modelReady) modelQ.push_back(refAlu(c, a, b));
        end
        @(negedge clk);
        checkOutput("out_valid", 32'(out_valid), 32'(modelQ.size() > 0));
        checkOutput("in_ready", 32'(in_ready), 32'(modelQ.size() < 2));
        if (modelQ.size() > 0) begin
            checkOutput("result", result, modelQ[0].result);
            checkOutput("zero", 32'(zero), 32'(modelQ[0].zero));
            checkOutput("overflow", 32'(overflow), 32'(modelQ[0].overflow));
            checkOutput("illegal", 32'(illegal), 32'(modelQ[0].illegal));
        end
    endtask

    task automatic idle(input logic r);
        applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, r, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] held;
        logic [3:0]  codes[5];
        logic [31:0] edges[6];
        logic [3:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;

        codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};

        in_valid  = 1'b0;
        alu_ctr   = 4'b0000;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_result", result, 32'h0);
        checkOutput("reset_zero", 32'(zero), 32'h0);
        checkOutput("reset_overflow", 32'(overflow), 32'h0);
        checkOutput("reset_illegal", 32'(illegal), 32'h0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'h1);

        applyStimulus(1'b1, 4'b0010, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, 1'b1);
        checkOutput("add_ovf_result", result, 32'h80000000);
        checkOutput("add_ovf_flag", 32'(overflow), 32'h1);
        checkOutput("add_ovf_zero", 32'(zero), 32'h0);

        applyStimulus(1'b1, 4'b0110, 32'h5, 32'h5, 1'b1, 1'b0, 1'b1);
        checkOutput("sub_zero_result", result, 32'h0);
        checkOutput("sub_zero_flag", 32'(zero), 32'h1);
        applyStimulus(1'b1, 4'b0111, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 1'b1);
        checkOutput("slt_neg", result, 32'h1);
        applyStimulus(1'b1, 4'b0111, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
        checkOutput("slt_extreme", result, 32'h1);
        checkOutput("slt_no_ovf", 32'(overflow), 32'h0);

        applyStimulus(1'b1, 4'b1111, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b1);
        checkOutput("illegal_result", result, 32'h0);
        checkOutput("illegal_zero", 32'(zero), 32'h1);
        checkOutput("illegal_flag", 32'(illegal), 32'h1);
        applyStimulus(1'b1, 4'b0000, 32'hF0F0, 32'h0FF0, 1'b1, 1'b0, 1'b1);
        checkOutput("and_result", result, 32'h00F0);
        applyStimulus(1'b1, 4'b0001, 32'hF000, 32'h000F, 1'b1, 1'b0, 1'b1);
        checkOutput("or_result", result, 32'hF00F);
        idle(1'b1);

        applyStimulus(1'b1, 4'b0010, 32'h10, 32'h1, 1'b0, 1'b0, 1'b1);
        held = result;
        applyStimulus(1'b1, 4'b0010, 32'h20, 32'h2, 1'b0, 1'b0, 1'b1);
        checkOutput("stall_in_ready", 32'(in_ready), 32'h0);
        applyStimulus(1'b1, 4'b0010, 32'h30, 32'h3, 1'b0, 1'b0, 1'b1);
        checkOutput("stall_stable", result, held);
        checkOutput("stall_first", result, 32'h11);
        idle(1'b1);
        checkOutput("release_in_ready", 32'(in_ready), 32'h1);
        checkOutput("release_second", result, 32'h22);
        idle(1'b1);
        checkOutput("release_drained", 32'(out_valid), 32'h0);

        applyStimulus(1'b1, 4'b0001, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'b0001, 32'h4, 32'h8, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'b0001, 32'hAA, 32'h55, 1'b0, 1'b1, 1'b1);
        checkOutput("flush_out_valid", 32'(out_valid), 32'h0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'h1);
        idle(1'b1);
        idle(1'b1);

        applyStimulus(1'b1, 4'b0001, 32'hF0, 32'h0F, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'b0010, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'b0010, 32'h1, 32'h1, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_mid_result", result, 32'h0);
        checkOutput("rst_mid_zero", 32'(zero), 32'h0);
        checkOutput("rst_mid_overflow", 32'(overflow), 32'h0);
        checkOutput("rst_mid_illegal", 32'(illegal), 32'h0);
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < 10000; i++) begin
            rc = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 4)];
            ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            applyStimulus($urandom_range(0, 3) != 0, rc, ra, rb, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 63) == 0, $urandom_range(0, 499) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
